// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - staged reset sequencer: memory, then peripherals, then core
module rst_sequencer #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int CNT_W       = $clog2((HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP) + 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sw_rst_req,
  input  logic       wdt_rst_req,
  output logic       mem_rst,
  output logic       periph_rst,
  output logic       core_rst,
  output logic       ready,
  output logic [1:0] rst_cause,
  output logic [7:0] soft_rst_cnt
);

  typedef enum logic [1:0] {
    S_HOLD       = 2'd0,
    S_REL_MEM    = 2'd1,
    S_REL_PERIPH = 2'd2,
    S_RUN        = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sff1_q, sff2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic [7:0]       scnt_q, scnt_d;
  logic             mem_rst_q, mem_rst_d;
  logic             periph_rst_q, periph_rst_d;
  logic             core_rst_q, core_rst_d;
  logic             ready_q, ready_d;

  // Two-flop synchronizer: asynchronous clear, synchronous release of reset_n
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sff1_q <= 1'b0;
      sff2_q <= 1'b0;
    end else begin
      sff1_q <= 1'b1;
      sff2_q <= sff1_q;
    end
  end

  // State, counter, cause/count bookkeeping and registered reset outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_HOLD;
      cnt_q        <= '0;
      cause_q      <= CAUSE_POR;
      scnt_q       <= 8'd0;
      mem_rst_q    <= 1'b1;
      periph_rst_q <= 1'b1;
      core_rst_q   <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cause_q      <= cause_d;
      scnt_q       <= scnt_d;
      mem_rst_q    <= mem_rst_d;
      periph_rst_q <= periph_rst_d;
      core_rst_q   <= core_rst_d;
      ready_q      <= ready_d;
    end
  end

  // Next-state logic; outputs decode from the next state so they are glitch-free flops
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    scnt_d  = scnt_q;

    case (state_q)
      S_HOLD: begin
        if (!sff2_q) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = S_REL_MEM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_REL_MEM: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_REL_PERIPH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_REL_PERIPH: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        // Requests only restart from RUN; watchdog takes priority in cause
        if (sw_rst_req || wdt_rst_req) begin
          state_d = S_HOLD;
          cause_d = wdt_rst_req ? CAUSE_WDT : CAUSE_SW;
          if (scnt_q != 8'hFF) begin
            scnt_d = scnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase

    mem_rst_d    = (state_d == S_HOLD);
    periph_rst_d = (state_d == S_HOLD) || (state_d == S_REL_MEM);
    core_rst_d   = (state_d != S_RUN);
    ready_d      = (state_d == S_RUN);
  end

  assign mem_rst      = mem_rst_q;
  assign periph_rst   = periph_rst_q;
  assign core_rst     = core_rst_q;
  assign ready        = ready_q;
  assign rst_cause    = cause_q;
  assign soft_rst_cnt = scnt_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - directed self-checking bench for rst_sequencer
module tb_rst_sequencer;

  localparam int HOLD = 16;
  localparam int GAP  = 4;

  logic       clk;
  logic       reset_n;
  logic       sw_rst_req;
  logic       wdt_rst_req;
  logic       mem_rst;
  logic       periph_rst;
  logic       core_rst;
  logic       ready;
  logic [1:0] rst_cause;
  logic [7:0] soft_rst_cnt;

  int vectors;
  int miscompares;

  rst_sequencer #(
    .HOLD_CYCLES(HOLD),
    .STAGE_GAP  (GAP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sw_rst_req  (sw_rst_req),
    .wdt_rst_req (wdt_rst_req),
    .mem_rst     (mem_rst),
    .periph_rst  (periph_rst),
    .core_rst    (core_rst),
    .ready       (ready),
    .rst_cause   (rst_cause),
    .soft_rst_cnt(soft_rst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n edges, sampling 1 time unit after each; check release ordering every cycle
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("order", {5'd0, core_rst, periph_rst, mem_rst},
          (!core_rst) ? 8'd0 : (!periph_rst) ? 8'd4 : {5'd0, 1'b1, 1'b1, mem_rst});
      chk("ready_vs_core", {7'd0, ready}, {7'd0, ~core_rst});
    end
  endtask

  task automatic pulse(input logic sw, input logic wdt);
    sw_rst_req  = sw;
    wdt_rst_req = wdt;
    step(1);
    sw_rst_req  = 1'b0;
    wdt_rst_req = 1'b0;
  endtask

  task automatic chk_outs(input string tag, input logic m, input logic p, input logic c, input logic r);
    chk({tag, "_mem"},    {7'd0, mem_rst},    {7'd0, m});
    chk({tag, "_periph"}, {7'd0, periph_rst}, {7'd0, p});
    chk({tag, "_core"},   {7'd0, core_rst},   {7'd0, c});
    chk({tag, "_ready"},  {7'd0, ready},      {7'd0, r});
  endtask

  // Called just after the edge that starts a sequence (edge 2 for POR, edge k for soft reset)
  task automatic check_release(input string tag);
    chk_outs({tag, "_k"}, 1, 1, 1, 0);
    step(HOLD - 1);
    chk_outs({tag, "_hold_end"}, 1, 1, 1, 0);
    step(1);
    chk_outs({tag, "_mem_rel"}, 0, 1, 1, 0);
    step(GAP - 1);
    chk_outs({tag, "_mem_gap"}, 0, 1, 1, 0);
    step(1);
    chk_outs({tag, "_per_rel"}, 0, 0, 1, 0);
    step(GAP - 1);
    chk_outs({tag, "_per_gap"}, 0, 0, 1, 0);
    step(1);
    chk_outs({tag, "_run"}, 0, 0, 0, 1);
  endtask

  task automatic por(input string tag);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outs({tag, "_in_reset"}, 1, 1, 1, 0);
    chk({tag, "_cause_rst"}, {6'd0, rst_cause}, 8'd0);
    chk({tag, "_cnt_rst"}, soft_rst_cnt, 8'd0);
    reset_n = 1'b1;
    step(2);
    check_release(tag);
    chk({tag, "_cause"}, {6'd0, rst_cause}, 8'd0);
    chk({tag, "_cnt"}, soft_rst_cnt, 8'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    sw_rst_req  = 1'b0;
    wdt_rst_req = 1'b0;
    #2;

    // Power-on: release edges 18 / 22 / 26
    por("por");

    // Software reset from RUN
    pulse(1, 0);
    check_release("sw");
    chk("sw_cause", {6'd0, rst_cause}, 8'd1);
    chk("sw_cnt", soft_rst_cnt, 8'd1);

    // Simultaneous requests: one restart, watchdog cause, count +1
    pulse(1, 1);
    check_release("both");
    chk("both_cause", {6'd0, rst_cause}, 8'd2);
    chk("both_cnt", soft_rst_cnt, 8'd2);

    // Software reset, then watchdog during REL_MEM is ignored
    pulse(1, 0);
    step(HOLD);
    chk_outs("ign_in_relmem", 0, 1, 1, 0);
    pulse(0, 1);
    step(2);
    chk_outs("ign_k19", 0, 1, 1, 0);
    step(1);
    chk_outs("ign_k20", 0, 0, 1, 0);
    step(GAP - 1);
    chk_outs("ign_k23", 0, 0, 1, 0);
    step(1);
    chk_outs("ign_k24", 0, 0, 0, 1);
    chk("ign_cause", {6'd0, rst_cause}, 8'd1);
    chk("ign_cnt", soft_rst_cnt, 8'd3);

    // Watchdog reset, then reset_n mid REL_PERIPH: immediate assertion
    pulse(0, 1);
    chk("wdt_cause", {6'd0, rst_cause}, 8'd2);
    chk("wdt_cnt", soft_rst_cnt, 8'd4);
    step(HOLD + GAP + 1);
    chk_outs("mid_relper", 0, 0, 1, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_outs("async_assert", 1, 1, 1, 0);
    chk("async_cause", {6'd0, rst_cause}, 8'd0);
    chk("async_cnt", soft_rst_cnt, 8'd0);
    por("por2");

    // Saturation of the soft reset count
    for (int i = 0; i < 260; i++) begin
      pulse(1, 0);
      chk("sat_cnt", soft_rst_cnt, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
      step(HOLD + 2 * GAP);
      chk("sat_ready", {7'd0, ready}, 8'd1);
    end
    chk("sat_final", soft_rst_cnt, 8'd255);
    chk("sat_cause", {6'd0, rst_cause}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
